uart_rx_loader: RTL and testbench
=================================

Name: uart_rx_loader

Overview:
- Upstream stage of the filter datapath. Deserialises bytes from the UART line (8N1, LSB first) and writes them to consecutive sample-memory addresses starting at 0.
- The filter later reads that memory through src/len/dest.
- Also reports fill level, framing errors and overflow, so the host can check that a full data set landed before it asserts begin_filter.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz clk, 115200 baud); must be >= 4.
- ADDR_W, 8, sample-memory address width; capacity is 2**ADDR_W bytes.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_serial  input  1  UART line, idle high, asynchronous to clk.
- clear  input  1  synchronous pulse: restart loading at address 0.
- mem_we  output  1  one-cycle memory write strobe.
- mem_addr  output  ADDR_W  write address, valid while mem_we=1.
- mem_wdata  output  8  received byte, valid while mem_we=1.
- byte_count  output  ADDR_W+1  bytes stored since reset/clear.
- full  output  1  high when byte_count == 2**ADDR_W.
- overflow  output  1  sticky: a valid byte arrived while full.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; wr_ptr = 0.
  - All outputs = 0.
  - Synchroniser flops = 1.
- rx_serial passes through a 2-flop synchroniser (reset value 1). All references below use the synchronised line rx_s.
- FSM states: IDLE, START, DATA, STOP, WRITE, WAIT_IDLE.
- IDLE:
  - rx_s=0 -> START, bit counter cleared.
- START:
  - Count CLKS_PER_BIT/2 cycles (integer division), then sample rx_s.
  - Sample 0 -> DATA.
  - Sample 1 -> IDLE (glitch). Nothing written, no error flagged.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into bit index 0..7 (LSB first).
  - After bit 7 -> STOP.
- STOP:
  - Wait CLKS_PER_BIT cycles, then sample rx_s.
  - Sample 1 -> WRITE.
  - Sample 0 -> frame_err=1 for exactly one cycle, byte discarded, -> WAIT_IDLE.
- WRITE (exactly one cycle, the cycle after the stop-bit sample):
  - If not full: mem_we=1, mem_addr=wr_ptr, mem_wdata=byte; wr_ptr and byte_count increment on the next edge.
  - If full: mem_we stays 0, overflow set (sticky), pointer unchanged.
  - Next state -> IDLE.
- WAIT_IDLE:
  - Stay until rx_s=1, then -> IDLE.
  - Prevents a low stop bit from being taken as the next start bit.
- Pointer rules:
  - No wrap-around. wr_ptr saturates logically via full.
  - byte_count maximum is 2**ADDR_W, which is why it is ADDR_W+1 bits wide.
- clear (only when rst=1):
  - Next edge: wr_ptr, byte_count, full and overflow are zeroed.
  - FSM state is unaffected; a byte in flight still completes.
  - If clear coincides with WRITE, clear wins and mem_we is forced to 0 (the byte is dropped).
- Latency: from the rx_serial falling edge at the start bit, mem_we rises after 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1 for edge alignment.
- Throughput: back-to-back frames with no idle gap are accepted. WRITE plus IDLE fit inside the remaining half stop bit.
- Reset mid-frame: the partial byte is lost, there is no write, and the next full frame goes to address 0.

Test Plan:
- Single frame 0xA5 at 8680 ns/bit -> exactly one mem_we, mem_addr=0, mem_wdata=0xA5; then byte_count=1, frame_err never high.
- Three back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> writes to addr 0/1/2 with those values, in order; byte_count=3.
- 200-cycle low glitch on an idle line -> no mem_we, no frame_err, busy returns to 0, and the next frame 0x11 writes addr 0.
- Frame 0x55 with its stop bit held low for 1.5 bit periods -> one frame_err pulse, no mem_we, FSM in WAIT_IDLE until the line rises; the next frame 0x66 writes addr 0.
- ADDR_W=2, five frames 1..5 -> four writes (addr 0..3, data 1..4), full=1 after the 4th write, fifth byte not written, overflow=1; a clear pulse then zeroes byte_count, full and overflow.
- rst low for 3 cycles in the middle of data bit 4 -> all outputs 0 immediately; the next frame 0x7E writes addr 0 with data 0x7E.

Source files
------------

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - UART 8N1 receiver that stores bytes to consecutive sample-memory addresses
module uart_rx_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_serial,
   input  logic              clear,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic [ADDR_W:0]   byte_count,
   output logic              full,
   output logic              overflow,
   output logic              frame_err,
   output logic              busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WRITE, WAIT_IDLE} state_t;

   state_t            state;
   logic              rx_m;
   logic              rx_s;
   logic [CW-1:0]     cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic [ADDR_W-1:0] wr_ptr;

   // byte_count never exceeds 2**ADDR_W, so its MSB alone marks the full condition
   assign full      = byte_count[ADDR_W];
   assign busy      = (state != IDLE);
   assign mem_we    = (state == WRITE) && !full && !clear;
   assign mem_addr  = wr_ptr;
   assign mem_wdata = shreg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         wr_ptr     <= '0;
         byte_count <= '0;
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_m      <= rx_serial;
         rx_s      <= rx_m;
         frame_err <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state   <= START;
                  cnt     <= '0;
                  bit_idx <= '0;
               end
            end
            START: begin
               if (cnt == HALF_END) begin
                  cnt   <= '0;
                  state <= rx_s ? IDLE : DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DATA: begin
               if (cnt == BIT_END) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            STOP: begin
               if (cnt == BIT_END) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= WRITE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= WAIT_IDLE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            WRITE:     state <= IDLE;
            // a low stop bit must not be mistaken for the next start bit
            WAIT_IDLE: if (rx_s) state <= IDLE;
            default:   state <= IDLE;
         endcase

         if (clear) begin
            wr_ptr     <= '0;
            byte_count <= '0;
            overflow   <= 1'b0;
         end else if (state == WRITE) begin
            if (full) begin
               overflow <= 1'b1;
            end else begin
               wr_ptr     <= wr_ptr + ADDR_W'(1);
               byte_count <= byte_count + (ADDR_W + 1)'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_loader.sv
// tb/tb_uart_rx_loader.sv - directed self-checking bench for uart_rx_loader
module tb_uart_rx_loader;

   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rx_a = 1'b1, rx_b = 1'b1;
   logic clr_a = 1'b0, clr_b = 1'b0;

   logic       mem_we_a, full_a, overflow_a, frame_err_a, busy_a;
   logic [7:0] mem_addr_a, mem_wdata_a;
   logic [8:0] byte_count_a;

   logic       mem_we_b, full_b, overflow_b, frame_err_b, busy_b;
   logic [1:0] mem_addr_b;
   logic [7:0] mem_wdata_b;
   logic [2:0] byte_count_b;

   int nvec = 0;
   int nerr = 0;

   logic [7:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
   int fe_a = 0;

   always #5 clk = ~clk;

   uart_rx_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) u_dut_a (
      .clk(clk), .rst(rst), .rx_serial(rx_a), .clear(clr_a),
      .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .byte_count(byte_count_a), .full(full_a), .overflow(overflow_a),
      .frame_err(frame_err_a), .busy(busy_a)
   );

   uart_rx_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2)) u_dut_b (
      .clk(clk), .rst(rst), .rx_serial(rx_b), .clear(clr_b),
      .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .byte_count(byte_count_b), .full(full_b), .overflow(overflow_b),
      .frame_err(frame_err_b), .busy(busy_b)
   );

   // write/error log, sampled mid-cycle
   always @(negedge clk) begin
      if (mem_we_a) begin qa_addr.push_back(mem_addr_a); qa_data.push_back(mem_wdata_a); end
      if (mem_we_b) begin qb_addr.push_back({6'd0, mem_addr_b}); qb_data.push_back(mem_wdata_b); end
      if (frame_err_a) fe_a++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int which, input logic v);
      if (which == 0) rx_a = v; else rx_b = v;
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input int stop_cycles, input logic stop_lvl);
      drive(which, 1'b0);
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         drive(which, d[i]);
         tick(CPB);
      end
      drive(which, stop_lvl);
      tick(stop_cycles);
   endtask

   task automatic clear_logs();
      qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
      fe_a = 0;
   endtask

   task automatic pulse_clear_a();
      clr_a = 1'b1; tick(1); clr_a = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(3);
      nvec++;
      if ({mem_we_a, mem_addr_a, mem_wdata_a, byte_count_a, full_a, overflow_a, frame_err_a, busy_a} !== '0) begin
         nerr++; $display("FAIL reset_a outputs=%h required 0", {mem_we_a, mem_addr_a, mem_wdata_a, byte_count_a, full_a, overflow_a, frame_err_a, busy_a});
      end
      nvec++;
      if ({mem_we_b, mem_addr_b, mem_wdata_b, byte_count_b, full_b, overflow_b, frame_err_b, busy_b} !== '0) begin
         nerr++; $display("FAIL reset_b outputs=%h required 0", {mem_we_b, mem_addr_b, mem_wdata_b, byte_count_b, full_b, overflow_b, frame_err_b, busy_b});
      end
      rst = 1'b1;
      tick(4);
   endtask

   task automatic test_single();
      clear_logs();
      send_frame(0, 8'hA5, CPB, 1'b1);
      tick(4);
      nvec++;
      if (qa_addr.size() !== 1) begin nerr++; $display("FAIL single_nwrites got %0d required 1", qa_addr.size()); end
      else begin
         nvec++;
         if (qa_addr[0] !== 8'h00 || qa_data[0] !== 8'hA5) begin
            nerr++; $display("FAIL single_write addr=%h data=%h required 00/a5", qa_addr[0], qa_data[0]);
         end
      end
      nvec++;
      if (byte_count_a !== 9'd1) begin nerr++; $display("FAIL single_count got %0d required 1", byte_count_a); end
      nvec++;
      if (fe_a !== 0 || busy_a !== 1'b0) begin nerr++; $display("FAIL single_idle fe=%0d busy=%b required 0/0", fe_a, busy_a); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d [3];
      exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h3C;
      pulse_clear_a();
      clear_logs();
      for (int i = 0; i < 3; i++) send_frame(0, exp_d[i], CPB, 1'b1);
      tick(4);
      nvec++;
      if (qa_addr.size() !== 3) begin nerr++; $display("FAIL b2b_nwrites got %0d required 3", qa_addr.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            nvec++;
            if (qa_addr[i] !== 8'(i) || qa_data[i] !== exp_d[i]) begin
               nerr++; $display("FAIL b2b_write%0d addr=%h data=%h required %h/%h", i, qa_addr[i], qa_data[i], 8'(i), exp_d[i]);
            end
         end
      end
      nvec++;
      if (byte_count_a !== 9'd3) begin nerr++; $display("FAIL b2b_count got %0d required 3", byte_count_a); end
   endtask

   task automatic test_glitch();
      pulse_clear_a();
      clear_logs();
      rx_a = 1'b0;
      tick(4);
      rx_a = 1'b1;
      tick(2);
      nvec++;
      if (busy_a !== 1'b1) begin nerr++; $display("FAIL glitch_busy_start got %b required 1", busy_a); end
      tick(30);
      nvec++;
      if (qa_addr.size() !== 0 || fe_a !== 0 || busy_a !== 1'b0) begin
         nerr++; $display("FAIL glitch_ignored writes=%0d fe=%0d busy=%b required 0/0/0", qa_addr.size(), fe_a, busy_a);
      end
      send_frame(0, 8'h11, CPB, 1'b1);
      tick(4);
      nvec++;
      if (qa_addr.size() !== 1 || qa_addr[0] !== 8'h00 || qa_data[0] !== 8'h11) begin
         nerr++; $display("FAIL glitch_next_frame writes=%0d required one write 00/11", qa_addr.size());
      end
   endtask

   task automatic test_frame_err();
      pulse_clear_a();
      clear_logs();
      send_frame(0, 8'h55, CPB + CPB / 2, 1'b0);
      nvec++;
      if (fe_a !== 1 || qa_addr.size() !== 0 || busy_a !== 1'b1) begin
         nerr++; $display("FAIL ferr_detect fe=%0d writes=%0d busy=%b required 1/0/1", fe_a, qa_addr.size(), busy_a);
      end
      rx_a = 1'b1;
      tick(5);
      nvec++;
      if (busy_a !== 1'b0 || fe_a !== 1) begin nerr++; $display("FAIL ferr_recover busy=%b fe=%0d required 0/1", busy_a, fe_a); end
      send_frame(0, 8'h66, CPB, 1'b1);
      tick(4);
      nvec++;
      if (qa_addr.size() !== 1 || qa_addr[0] !== 8'h00 || qa_data[0] !== 8'h66 || byte_count_a !== 9'd1) begin
         nerr++; $display("FAIL ferr_next_frame writes=%0d count=%0d required one write 00/66 count 1", qa_addr.size(), byte_count_a);
      end
   endtask

   task automatic test_overflow();
      clear_logs();
      for (int i = 1; i <= 5; i++) send_frame(1, 8'(i), CPB, 1'b1);
      tick(4);
      nvec++;
      if (qb_addr.size() !== 4) begin nerr++; $display("FAIL ovf_nwrites got %0d required 4", qb_addr.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            nvec++;
            if (qb_addr[i] !== 8'(i) || qb_data[i] !== 8'(i + 1)) begin
               nerr++; $display("FAIL ovf_write%0d addr=%h data=%h required %h/%h", i, qb_addr[i], qb_data[i], 8'(i), 8'(i + 1));
            end
         end
      end
      nvec++;
      if (full_b !== 1'b1 || overflow_b !== 1'b1 || byte_count_b !== 3'd4) begin
         nerr++; $display("FAIL ovf_flags full=%b ovf=%b count=%0d required 1/1/4", full_b, overflow_b, byte_count_b);
      end
      clr_b = 1'b1; tick(1); clr_b = 1'b0;
      nvec++;
      if (full_b !== 1'b0 || overflow_b !== 1'b0 || byte_count_b !== 3'd0) begin
         nerr++; $display("FAIL ovf_clear full=%b ovf=%b count=%0d required 0/0/0", full_b, overflow_b, byte_count_b);
      end
   endtask

   task automatic test_reset_mid();
      clear_logs();
      nvec++;
      if (byte_count_a !== 9'd1) begin nerr++; $display("FAIL rstmid_pre_count got %0d required 1", byte_count_a); end
      rx_a = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin rx_a = i[0]; tick(CPB); end
      rx_a = 1'b1;
      tick(CPB / 2);
      rst = 1'b0;
      #1;
      nvec++;
      if ({mem_we_a, mem_addr_a, mem_wdata_a, byte_count_a, full_a, overflow_a, frame_err_a, busy_a} !== '0) begin
         nerr++; $display("FAIL rstmid_outputs=%h required 0", {mem_we_a, mem_addr_a, mem_wdata_a, byte_count_a, full_a, overflow_a, frame_err_a, busy_a});
      end
      tick(3);
      rst = 1'b1;
      tick(3 * CPB);
      nvec++;
      if (qa_addr.size() !== 0 || busy_a !== 1'b0) begin nerr++; $display("FAIL rstmid_no_write writes=%0d busy=%b required 0/0", qa_addr.size(), busy_a); end
      send_frame(0, 8'h7E, CPB, 1'b1);
      tick(4);
      nvec++;
      if (qa_addr.size() !== 1 || qa_addr[0] !== 8'h00 || qa_data[0] !== 8'h7E) begin
         nerr++; $display("FAIL rstmid_next_frame writes=%0d required one write 00/7e", qa_addr.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_overflow();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
